// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM encoding and requester ids for ram_arbiter
package ram_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the port not granted last wins
module rr_arb2
  import ram_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);
  assign o_gnt[0] = i_req[0] & (~i_req[1] | (i_last == PORT1));
  assign o_gnt[1] = i_req[1] & (~i_req[0] | (i_last == PORT0));
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one registered-output RAM between two requesters, one transaction in flight
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_req_valid,
  output logic             p0_req_ready,
  input  logic             p0_req_we,
  input  logic [DEPTH-1:0] p0_req_addr,
  input  logic [WIDTH-1:0] p0_req_wdata,
  output logic             p0_rsp_valid,
  input  logic             p0_rsp_ready,
  output logic [31:0]      p0_rsp_rdata,
  input  logic             p1_req_valid,
  output logic             p1_req_ready,
  input  logic             p1_req_we,
  input  logic [DEPTH-1:0] p1_req_addr,
  input  logic [WIDTH-1:0] p1_req_wdata,
  output logic             p1_rsp_valid,
  input  logic             p1_rsp_ready,
  output logic [31:0]      p1_rsp_rdata,
  output logic             ram_write_enable,
  output logic [WIDTH-1:0] ram_data,
  output logic [DEPTH-1:0] ram_address,
  input  logic [31:0]      ram_data_out
);
  state_t           r_state;
  logic             r_last;
  logic             r_gnt;
  logic             r_we;
  logic [DEPTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [31:0]      r_rdata;
  logic [1:0]       w_gnt;
  logic             w_idle;
  logic             w_busy;
  logic             w_rsp_ready;
  rr_arb2 u_arb (
    .i_req  ({p1_req_valid, p0_req_valid}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );
  // ready is combinational on valid, so it is also masked while reset is held
  assign w_idle       = (r_state == IDLE) && rst_n;
  assign w_busy       = (r_state == ISSUE) || (r_state == WAIT);
  assign w_rsp_ready  = (r_gnt == PORT1) ? p1_rsp_ready : p0_rsp_ready;
  assign p0_req_ready = w_idle & w_gnt[0];
  assign p1_req_ready = w_idle & w_gnt[1];
  assign p0_rsp_valid = (r_state == RESP) && (r_gnt == PORT0);
  assign p1_rsp_valid = (r_state == RESP) && (r_gnt == PORT1);
  assign p0_rsp_rdata = (r_gnt == PORT0) ? r_rdata : '0;
  assign p1_rsp_rdata = (r_gnt == PORT1) ? r_rdata : '0;
  assign ram_write_enable = (r_state == ISSUE) && r_we;
  assign ram_address      = w_busy ? r_addr : '0;
  assign ram_data         = w_busy ? r_wdata : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= PORT1;
      r_gnt   <= PORT0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (|w_gnt) begin
          r_gnt   <= w_gnt[1];
          r_last  <= w_gnt[1];
          r_we    <= w_gnt[1] ? p1_req_we : p0_req_we;
          r_addr  <= w_gnt[1] ? p1_req_addr : p0_req_addr;
          r_wdata <= w_gnt[1] ? p1_req_wdata : p0_req_wdata;
          r_state <= ISSUE;
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          r_rdata <= r_we ? '0 : ram_data_out;
          r_state <= RESP;
        end
        RESP: if (w_rsp_ready) r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
  logic        clk;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready;
  logic [9:0]  p0_req_addr;
  logic [7:0]  p0_req_wdata;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_ready;
  logic [9:0]  p1_req_addr;
  logic [7:0]  p1_req_wdata;
  logic [31:0] p1_rsp_rdata;
  logic        ram_write_enable;
  logic [7:0]  ram_data;
  logic [9:0]  ram_address;
  logic [31:0] ram_data_out;
  logic [31:0] mem [0:1023];
  int          n_chk = 0;
  int          n_fail = 0;
  ram_arbiter #(.DEPTH(10), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .ram_write_enable(ram_write_enable), .ram_data(ram_data),
    .ram_address(ram_address), .ram_data_out(ram_data_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= {24'h0, ram_data};
    else ram_data_out <= mem[ram_address];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic rdy(input int p);
    return (p == 1) ? p1_req_ready : p0_req_ready;
  endfunction
  function automatic logic rsp_v(input int p);
    return (p == 1) ? p1_rsp_valid : p0_rsp_valid;
  endfunction
  function automatic logic [31:0] rsp_d(input int p);
    return (p == 1) ? p1_rsp_rdata : p0_rsp_rdata;
  endfunction
  task automatic set_req(input int p, input logic v, input logic we, input logic [9:0] a, input logic [7:0] d);
    if (p == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
    end
  endtask
  task automatic set_rr(input int p, input logic v);
    if (p == 0) p0_rsp_ready = v;
    else p1_rsp_ready = v;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input int p, input logic we, input logic [9:0] a, input logic [7:0] d);
    set_req(p, 1'b1, we, a, d);
    #1;
    chk("req_ready", rdy(p), 1);
    chk("other_ready", rdy(1 - p), 0);
    step();
    set_req(p, 1'b0, we, a, d);
    #1;
    chk("issue_we", ram_write_enable, we);
    chk("issue_addr", ram_address, a);
    if (we) chk("issue_data", ram_data, d);
    chk("issue_ready", {p1_req_ready, p0_req_ready}, 0);
  endtask
  task automatic txn(input int p, input logic we, input logic [9:0] a, input logic [7:0] d,
                     input logic [31:0] exp, input int hold);
    req(p, we, a, d);
    step();
    chk("wait_we", ram_write_enable, 0);
    chk("wait_addr", ram_address, a);
    chk("wait_rsp", {p1_rsp_valid, p0_rsp_valid}, 0);
    step();
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", rsp_v(p), 1);
      chk("rsp_other", rsp_v(1 - p), 0);
      chk("rsp_rdata", rsp_d(p), exp);
      chk("rsp_req_ready", {p1_req_ready, p0_req_ready}, 0);
      chk("rsp_we", ram_write_enable, 0);
      if (i < hold) begin
        set_rr(1 - p, 1'b1);
        step();
      end
    end
    set_rr(1 - p, 1'b0);
    set_rr(p, 1'b1);
    step();
    set_rr(p, 1'b0);
    chk("rsp_done", rsp_v(p), 0);
  endtask
  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 10'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 10'h0, 8'h0);
    p0_rsp_ready = 1'b0;
    p1_rsp_ready = 1'b0;
    #1;
    chk("reset_ctl", {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, ram_write_enable}, 0);
    chk("reset_addr", ram_address, 0);
    chk("reset_data", ram_data, 0);
    chk("reset_rdata", {p0_rsp_rdata | p1_rsp_rdata}, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    txn(0, 1'b1, 10'h005, 8'hA5, 32'h0, 0);
    txn(0, 1'b0, 10'h005, 8'h00, 32'h0000_00A5, 0);
    txn(1, 1'b1, 10'h3FF, 8'h3C, 32'h0, 0);
    txn(0, 1'b0, 10'h3FF, 8'h00, 32'h0000_003C, 0);
    txn(0, 1'b1, 10'h000, 8'hFF, 32'h0, 0);
    txn(1, 1'b0, 10'h000, 8'h00, 32'h0000_00FF, 0);
    set_req(1, 1'b1, 1'b0, 10'h3FF, 8'h00);
    txn(0, 1'b0, 10'h005, 8'h00, 32'h0000_00A5, 0);
    set_req(0, 1'b1, 1'b0, 10'h000, 8'h00);
    txn(1, 1'b0, 10'h3FF, 8'h00, 32'h0000_003C, 5);
    txn(0, 1'b0, 10'h000, 8'h00, 32'h0000_00FF, 0);
    req(1, 1'b0, 10'h005, 8'h00);
    step();
    set_req(0, 1'b1, 1'b0, 10'h005, 8'h00);
    set_req(1, 1'b1, 1'b0, 10'h3FF, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("wait_rst_ctl", {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, ram_write_enable}, 0);
    chk("wait_rst_addr", ram_address, 0);
    chk("wait_rst_rdata", {p0_rsp_rdata | p1_rsp_rdata}, 0);
    set_req(0, 1'b0, 1'b0, 10'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 10'h0, 8'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_p1_rsp", p1_rsp_valid, 0);
    end
    req(0, 1'b1, 10'h005, 8'h11);
    rst_n = 1'b0;
    #1;
    chk("issue_rst_we", ram_write_enable, 0);
    step();
    rst_n = 1'b1;
    #1;
    set_req(1, 1'b1, 1'b0, 10'h3FF, 8'h00);
    txn(0, 1'b0, 10'h005, 8'h00, 32'h0000_00A5, 0);
    txn(1, 1'b0, 10'h3FF, 8'h00, 32'h0000_003C, 0);
    for (int i = 0; i < 20; i++) begin
      set_req(0, 1'b1, 1'b0, 10'h005, 8'h00);
      set_req(1, 1'b1, 1'b0, 10'h3FF, 8'h00);
      txn(i % 2, 1'b0, (i % 2 == 1) ? 10'h3FF : 10'h005, 8'h00,
          (i % 2 == 1) ? 32'h0000_003C : 32'h0000_00A5, 0);
    end
    set_req(0, 1'b0, 1'b0, 10'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 10'h0, 8'h0);
    step();
    chk("final_idle", {p0_rsp_valid, p1_rsp_valid, ram_write_enable}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
